// File: rtl/ps2_tx_if.sv
// Host-side request/status bundle for the PS/2 transmitter.
// Master issues bytes; slave (ps2_tx) reports ready/done/error/busy.
interface ps2_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_error,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_error,
        output busy
    );
endinterface

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, start, 8 data bits,
// odd parity, stop, device ACK; pins are driven open-drain via OEs.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int START_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    ps2_tx_if.slave tx,
    input  logic ps2clk,
    input  logic ps2dat,
    output logic ps2clk_oe,
    output logic ps2dat_oe
);

    localparam int CW = $clog2(INHIBIT_CYCLES + START_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] STA_LAST = CW'(START_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            clk_oe_q, clk_oe_d;
    logic            dat_oe_q, dat_oe_d;
    logic [1:0]      csync_q, dsync_q;
    logic            clk_prev_q;
    logic            clk_s, dat_s, fe;
    logic            cur_bit;
    logic            done, err;

    assign clk_s = csync_q[1];
    assign dat_s = dsync_q[1];
    assign fe    = clk_prev_q & ~clk_s;

    // Two-flop synchronizers for both pins plus the edge-detect history.
    // Reset to 1 (idle line level) so no false edge appears after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csync_q    <= 2'b11;
            dsync_q    <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            csync_q    <= {csync_q[0], ps2clk};
            dsync_q    <= {dsync_q[0], ps2dat};
            clk_prev_q <= clk_s;
        end
    end

    // Level of the frame bit selected by the bit counter.
    always_comb begin
        cur_bit = 1'b1;
        if (bit_q < 4'd8) begin
            cur_bit = data_q[bit_q[2:0]];
        end else if (bit_q == 4'd8) begin
            cur_bit = ~^data_q;
        end
    end

    // Frame sequencer: next state, counters, pin enables, pulses.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wd_d     = wd_q;
        bit_d    = bit_q;
        data_d   = data_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx.tx_valid) begin
                    data_d   = tx.tx_data;
                    clk_oe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = S_START;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_START: begin
                if (cnt_q == STA_LAST) begin
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    wd_d     = '0;
                    bit_d    = '0;
                    state_d  = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                if (fe) begin
                    wd_d     = '0;
                    dat_oe_d = ~cur_bit;
                    if (bit_q == 4'd9) begin
                        state_d = S_ACK;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else if (wd_q == WD_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err      = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            S_ACK: begin
                if (fe) begin
                    if (!dat_s) begin
                        wd_d    = '0;
                        state_d = S_RELEASE;
                    end else begin
                        clk_oe_d = 1'b0;
                        dat_oe_d = 1'b0;
                        err      = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else if (wd_q == WD_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err      = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            S_RELEASE: begin
                if (clk_s && dat_s) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (fe) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err      = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // Sequencer state; reset releases both lines immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wd_q     <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    assign ps2clk_oe   = clk_oe_q;
    assign ps2dat_oe   = dat_oe_q;
    assign tx.tx_ready = (state_q == S_IDLE);
    assign tx.busy     = (state_q != S_IDLE);
    assign tx.tx_done  = done;
    assign tx.tx_error = err;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: keyboard model on the open-drain pins,
// table of frames plus timeout and mid-frame reset sequences.
module tb_ps2_tx;

    localparam int INH = 20;
    localparam int STA = 4;
    localparam int TO  = 200;
    localparam int H   = 10;

    logic clk;
    logic reset;
    logic ps2clk_oe, ps2dat_oe;
    logic dev_clk, dev_dat;
    logic ps2clk, ps2dat;

    ps2_tx_if tx ();

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .START_CYCLES  (STA),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx       (tx),
        .ps2clk   (ps2clk),
        .ps2dat   (ps2dat),
        .ps2clk_oe(ps2clk_oe),
        .ps2dat_oe(ps2dat_oe)
    );

    assign ps2clk = ~ps2clk_oe & dev_clk;
    assign ps2dat = ~ps2dat_oe & dev_dat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_cyc = 0;
    logic chk_next = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Pulse monitor: counts done/error and checks the cycle after each.
    always @(negedge clk) begin
        if (chk_next) begin
            chk("ready_after_pulse", {31'd0, tx.tx_ready}, 32'd1);
            chk("oe_after_pulse", {30'd0, ps2clk_oe, ps2dat_oe}, 32'd0);
        end
        if (tx.tx_done || tx.tx_error)
            chk("pulse_excl", {31'd0, tx.tx_done & tx.tx_error}, 32'd0);
        if (tx.tx_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (tx.tx_error) err_cnt++;
        chk_next = (tx.tx_done || tx.tx_error) && !reset;
    end

    task automatic dev_clock(input logic pull, output logic s);
        if (pull) begin
            dev_dat = 1'b0;
            repeat (2) tick();
        end
        dev_clk = 1'b0;
        repeat (H) tick();
        s = ps2dat_oe;
        dev_clk = 1'b1;
        repeat (H) tick();
        dev_dat = 1'b1;
    endtask

    // Request a byte and wait through inhibit/start; returns counts.
    task automatic start_frame(input logic [7:0] d, input logic hold,
                               input logic [7:0] nxt, output int acc,
                               output int cn, output int dn);
        int n;
        tx.tx_data  = d;
        tx.tx_valid = 1'b1;
        n = 0;
        while (!tx.tx_ready && n < 500) begin
            tick();
            n++;
        end
        chk("accept_wait", {31'd0, tx.tx_ready}, 32'd1);
        tick();
        acc = cyc;
        if (hold) tx.tx_data = nxt;
        else tx.tx_valid = 1'b0;
        cn = 0;
        dn = 0;
        while (ps2clk_oe && cn < 1000) begin
            cn++;
            if (ps2dat_oe) dn++;
            tick();
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       hold;
        logic [7:0] nxt;
        logic [9:0] exp_oe;
        logic       exp_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc, cn, dn, d0, e0, n;
        logic [9:0] seen;
        logic s;
        logic prev_hold;

        vecs[0] = '{8'hFF, 1'b1, 1'b0, 8'h00, 10'h000, 1'b1};
        vecs[1] = '{8'hF4, 1'b1, 1'b0, 8'h00, 10'h10B, 1'b1};
        vecs[2] = '{8'hED, 1'b1, 1'b1, 8'h02, 10'h012, 1'b1};
        vecs[3] = '{8'h02, 1'b1, 1'b0, 8'h00, 10'h1FD, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 10'h0FF, 1'b1};
        vecs[5] = '{8'h55, 1'b0, 1'b0, 8'h00, 10'h0AA, 1'b0};

        reset = 1'b1;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        tx.tx_data = 8'h00;
        tx.tx_valid = 1'b0;
        #23;
        chk("rst_oe", {30'd0, ps2clk_oe, ps2dat_oe}, 32'd0);
        chk("rst_ready", {31'd0, tx.tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, tx.busy}, 32'd0);
        chk("rst_pulses", {30'd0, tx.tx_done, tx.tx_error}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        prev_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            start_frame(vecs[i].data, vecs[i].hold, vecs[i].nxt,
                        acc, cn, dn);
            if (prev_hold)
                chk("b2b_accept_cyc", acc, done_cyc + 2);
            chk("clk_oe_len", cn, INH + STA);
            chk("dat_oe_start_len", dn, STA);
            repeat (H) tick();
            for (int k = 0; k < 10; k++) begin
                dev_clock(1'b0, s);
                seen[k] = s;
            end
            chk("oe_seq", {22'd0, seen}, {22'd0, vecs[i].exp_oe});
            dev_clock(vecs[i].ack, s);
            n = 0;
            while (done_cnt + err_cnt == d0 + e0 && n < 100) begin
                tick();
                n++;
            end
            chk("done_cnt", done_cnt - d0, {31'd0, vecs[i].exp_done});
            chk("err_cnt", err_cnt - e0, {31'd0, ~vecs[i].ack});
            prev_hold = vecs[i].hold;
        end

        // Device never clocks: watchdog fires TO cycles after START exit.
        repeat (5) tick();
        d0 = done_cnt;
        start_frame(8'hF4, 1'b0, 8'h00, acc, cn, dn);
        n = 0;
        while (!tx.tx_error && n < TO + 50) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, TO);
        tick();
        chk("timeout_no_done", done_cnt - d0, 32'd0);

        // Asynchronous reset while shifting bit 4 of 0xF4.
        repeat (5) tick();
        start_frame(8'hF4, 1'b0, 8'h00, acc, cn, dn);
        repeat (H) tick();
        for (int k = 0; k < 4; k++) dev_clock(1'b0, s);
        chk("pre_reset_dat_oe", {31'd0, ps2dat_oe}, 32'd1);
        chk("pre_reset_busy", {31'd0, tx.busy}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_oe", {30'd0, ps2clk_oe, ps2dat_oe}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, tx.tx_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, tx.busy}, 32'd0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter for the Z88 keyboard path. It sends command bytes such as 0xFF (reset), 0xED plus an LED mask, or 0xF4 (enable) to the attached keyboard. It shares the PS/2 clock and data wires with the existing receive decoder, driving them open-drain through output-enable pins. While a transfer is in progress it raises `busy` so the receive path can suppress the device's clocking of the host frame.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 2500: number of `clk` cycles the PS/2 clock is held low before the start bit (at least 100 µs).
- `START_CYCLES`, default 16: number of `clk` cycles data and clock are both held low before the clock is released.
- `TIMEOUT_CYCLES`, default 50000: maximum `clk` cycles allowed between device clock falling edges, and for the final release, before the transfer is aborted.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  asynchronous reset, active-high.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  request; the byte is accepted when `tx_valid && tx_ready`.
- `tx_ready`  out  1  high only in IDLE.
- `tx_done`  out  1  one-cycle pulse when the device acknowledges the frame.
- `tx_error`  out  1  one-cycle pulse on a missing ACK or a timeout.
- `busy`  out  1  high in every state except IDLE.
- `ps2clk`  in  1  PS/2 clock pin level (asynchronous).
- `ps2dat`  in  1  PS/2 data pin level (asynchronous).
- `ps2clk_oe`  out  1  1 = drive the clock line low; 0 = release it.
- `ps2dat_oe`  out  1  1 = drive the data line low; 0 = release it.

## Operation
- `ps2clk` and `ps2dat` each pass through a 2-flop synchronizer. A falling edge (`fe`) is registered when the synchronized clock goes from 1 to 0.
- The byte is latched on acceptance. The odd-parity bit is `~^tx_data`. The line-drive rule is `ps2dat_oe = ~bit`.
- States:
  - IDLE: both OEs are 0 and `tx_ready` = 1. On accept, go to INHIBIT.
  - INHIBIT: `ps2clk_oe` = 1 and `ps2dat_oe` = 0 for `INHIBIT_CYCLES` cycles, then go to START.
  - START: `ps2clk_oe` = 1 and `ps2dat_oe` = 1 (start bit 0) for `START_CYCLES` cycles, then go to SHIFT with `ps2clk_oe` = 0.
  - SHIFT: a bit counter k runs 0..9. On each `fe`, drive bit k as follows:
    - k = 0..7: `tx_data[k]`, LSB first.
    - k = 8: parity.
    - k = 9: stop bit, data released (`ps2dat_oe` = 0).
    - After the k = 9 drive, go to ACK.
  - ACK: on the next `fe`, sample the synchronized data. If it is 0 (device ACK), go to RELEASE. If it is 1, pulse `tx_error` and go to IDLE.
  - RELEASE: wait until both synchronized clock and data are 1, then pulse `tx_done` and go to IDLE.
- Timeout: in SHIFT, ACK and RELEASE, a watchdog counter restarts at every `fe`, and at entry to RELEASE. When it reaches `TIMEOUT_CYCLES`, both OEs are released, `tx_error` pulses and the block returns to IDLE.
- `tx_valid` is ignored while `busy` is 1; no request is queued.
- The block never drives a line high. The OEs are the only pin controls.

## Timing
- Reset values: state IDLE, `ps2clk_oe` = 0, `ps2dat_oe` = 0, `tx_ready` = 1, `busy` = 0, `tx_done` = 0, `tx_error` = 0, counters 0. Reset takes effect asynchronously, including mid-frame; both lines are released immediately.
- Handshake: on the accept edge, `ps2clk_oe` goes to 1 and `tx_ready` goes to 0 at the next edge.
- Inhibit and start: `ps2clk_oe` is 1 for exactly `INHIBIT_CYCLES + START_CYCLES` cycles. `ps2dat_oe` is 1 for the last `START_CYCLES` of those cycles.
- Pin to OE latency: a pin falling edge changes `ps2dat_oe` 3 `clk` cycles later (2 synchronizer flops plus 1 registered update). This is well inside the PS/2 low half-period.
- `tx_done` and `tx_error` are mutually exclusive, last one cycle, and are asserted together with the transition to IDLE. `tx_ready` is 1 in the following cycle.
- If an `fe` and the timeout terminal count fall in the same cycle, the `fe` wins and the timeout does not fire.

## Test plan
- Send 0xFF to a keyboard model. Required: `ps2dat_oe` sequence after each `fe` is 0,0,0,0,0,0,0,0 (data bits), 0 (parity = 1), 0 (stop). The model ACKs, then `tx_done` pulses once and `tx_error` stays 0.
- Send 0xF4. Required: data bits LSB first are 0,0,1,0,1,1,1,1 and parity is 0, so `ps2dat_oe` = 1,1,0,1,0,0,0,0, then 1 (parity 0), then 0 (stop).
- Send 0xED, then 0x02, back-to-back, with `tx_valid` held high. Required: the second byte is accepted only in the cycle after `tx_done`, and pulses asserted during `busy` are ignored.
- The model holds data high at the ACK clock. Required: a `tx_error` pulse, both OEs 0, and `tx_ready` = 1 in the next cycle.
- The model never clocks after the clock is released. Required: `tx_error` exactly `TIMEOUT_CYCLES` cycles after START exits, and no `tx_done`.
- Assert `reset` asynchronously during SHIFT at k = 4. Required: both OEs are 0 before the next `clk` edge, and after reset the block is in IDLE with `tx_ready` = 1.
